// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: next-PC select, instruction/data words,
// fetch FSM states and the sequential PC step.
package fetch_unit_pkg;

    typedef logic [31:0] instr;
    typedef logic [31:0] data_val;

    // Three bits wide so that unused encodings exist; they behave as PC_INCR.
    typedef enum logic [2:0] {
        PC_INCR    = 3'd0,
        PC_IMM_OFF = 3'd1,
        PC_ALU_OUT = 3'd2,
        PC_RST     = 3'd3
    } pc_sel;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2,
        F_HOLD = 2'd3
    } fetch_state;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC target selection for the fetch stage, plus a flag
// telling whether the selected target is not word aligned.
module pc_next
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic [31:0] pc,
    input  pc_sel       sel,
    input  data_val     imm_val,
    input  data_val     alu_out,
    output logic [31:0] target,
    output logic        misalign
);

    // JALR targets always drop bit 0; bit 1 can still leave the target misaligned.
    always_comb begin
        target = pc + PC_STEP;
        case (sel)
            PC_IMM_OFF: target = pc + imm_val;
            PC_ALU_OUT: target = alu_out & 32'hFFFF_FFFE;
            PC_RST:     target = RESET_PC;
            default:    target = pc + PC_STEP;
        endcase
        misalign = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time and holds
// the instruction until retire. Optional FETCH_ALIGN_CHECK_EN adds a sticky fault.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output instr        o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_incr,
    input  pc_sel       i_pc_sel,
    input  data_val     i_imm_val,
    input  data_val     i_alu_out,
    output logic        o_fault
);

    fetch_state  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    instr        instr_q, instr_d;
    logic [31:0] target;
    logic        misalign;
    logic [31:0] next_pc;

    pc_next #(
        .RESET_PC (RESET_PC)
    ) u_pc_next (
        .pc       (pc_q),
        .sel      (i_pc_sel),
        .imm_val  (i_imm_val),
        .alu_out  (i_alu_out),
        .target   (target),
        .misalign (misalign)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    // Misaligned targets are kept as-is so the faulting address is visible.
    assign next_pc = target;
    assign o_fault = fault_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign next_pc = misalign ? {target[31:2], 2'b00} : target;
    assign o_fault = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= F_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // A fault parks the FSM in F_IDLE until the next reset.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d = fault_q;
`endif
        case (state_q)
            F_IDLE: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (!fault_q) begin
                    state_d = F_REQ;
                end
`else
                state_d = F_REQ;
`endif
            end
            F_REQ: begin
                if (i_imem_req_ready) begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (i_imem_rsp_valid) begin
                    instr_d = i_imem_rsp_data;
                    state_d = F_HOLD;
                end
            end
            F_HOLD: begin
                if (i_instr_ready) begin
                    pc_d    = next_pc;
                    state_d = F_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (misalign) begin
                        fault_d = 1'b1;
                        state_d = F_IDLE;
                    end
`endif
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    assign o_imem_req_valid = (state_q == F_REQ);
    assign o_instr_valid    = (state_q == F_HOLD);
    assign o_imem_addr      = pc_q;
    assign o_pc             = pc_q;
    assign o_pc_incr        = pc_q + PC_STEP;
    assign o_instr          = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of fetch/retire vectors plus
// hand-written stall, misaligned-target and reset-during-wait sequences.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_instr_valid;
    logic        i_instr_ready;
    instr        o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_incr;
    pc_sel       i_pc_sel;
    data_val     i_imm_val;
    data_val     i_alu_out;
    logic        o_fault;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] pc_incr;
    } vec_t;

    vec_t vecs [10];

    fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_instr_valid    (o_instr_valid),
        .i_instr_ready    (i_instr_ready),
        .o_instr          (o_instr),
        .o_pc             (o_pc),
        .o_pc_incr        (o_pc_incr),
        .i_pc_sel         (i_pc_sel),
        .i_imm_val        (i_imm_val),
        .i_alu_out        (i_alu_out),
        .o_fault          (o_fault)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One full fetch: wait for the request, accept, respond, hold, then retire.
    task automatic apply_stimulus(input vec_t v);
        int n = 0;
        while (!o_imem_req_valid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check_bit("req_valid", o_imem_req_valid, 1'b1);
        check_word("imem_addr", o_imem_addr, v.pc);
        i_imem_req_ready = 1'b1;
        @(negedge i_clk);
        i_imem_req_ready = 1'b0;
        check_bit("req_after_accept", o_imem_req_valid, 1'b0);
        check_bit("valid_in_wait", o_instr_valid, 1'b0);
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = v.data;
        @(negedge i_clk);
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'hBAD0_BAD0;
        i_pc_sel         = PC_RST;
        check_bit("instr_valid", o_instr_valid, 1'b1);
        check_word("instr", o_instr, v.data);
        @(negedge i_clk);
        check_bit("hold_valid", o_instr_valid, 1'b1);
        check_word("hold_instr", o_instr, v.data);
        check_word("hold_pc", o_pc, v.pc);
        check_word("pc_incr", o_pc_incr, v.pc_incr);
        i_pc_sel      = pc_sel'(v.sel);
        i_imm_val     = v.imm;
        i_alu_out     = v.alu;
        i_instr_ready = 1'b1;
        @(negedge i_clk);
        i_instr_ready = 1'b0;
        i_pc_sel      = PC_RST;
        check_bit("valid_after_retire", o_instr_valid, 1'b0);
        check_bit("req_after_retire", o_imem_req_valid, 1'b1);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0050_0093, 3'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004};
        vecs[1] = '{32'h0000_0004, 32'h00A0_0113, 3'd1, 32'h0000_001C, 32'hDEAD_BEEF, 32'h0000_0008};
        vecs[2] = '{32'h0000_0020, 32'h0020_81B3, 3'd1, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0024};
        vecs[3] = '{32'h0000_0018, 32'h0000_80E7, 3'd2, 32'h0000_0040, 32'h0000_0105, 32'h0000_001C};
        vecs[4] = '{32'h0000_0104, 32'h0000_0013, 3'd6, 32'h0000_0100, 32'h0000_0200, 32'h0000_0108};
        vecs[5] = '{32'h0000_0108, 32'h0000_006F, 3'd3, 32'h0000_0004, 32'h0000_0008, 32'h0000_010C};
        vecs[6] = '{32'h0000_0000, 32'h0050_0093, 3'd1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0013, 3'd0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{32'h0000_0000, 32'h0050_0093, 3'd1, 32'h0000_0010, 32'h0000_0000, 32'h0000_0004};
        vecs[9] = '{32'h0000_0010, 32'h00C0_0193, 3'd0, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0014};

        i_rst_n          = 1'b0;
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'h0;
        i_instr_ready    = 1'b0;
        i_pc_sel         = PC_INCR;
        i_imm_val        = 32'h0;
        i_alu_out        = 32'h0;

        repeat (2) @(negedge i_clk);
        check_bit("rst_req_valid", o_imem_req_valid, 1'b0);
        check_bit("rst_instr_valid", o_instr_valid, 1'b0);
        check_word("rst_pc", o_pc, 32'h0);
        check_word("rst_instr", o_instr, 32'h0);
        check_bit("rst_fault", o_fault, 1'b0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_bit("req_one_after_release", o_imem_req_valid, 1'b1);
        check_word("first_addr", o_imem_addr, 32'h0);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Memory stalls three cycles; the request must hold steady.
        for (int c = 0; c < 3; c++) begin
            check_bit("stall_req_valid", o_imem_req_valid, 1'b1);
            check_word("stall_addr", o_imem_addr, 32'h0000_0014);
            @(negedge i_clk);
        end
        check_bit("stall_req_valid4", o_imem_req_valid, 1'b1);
        check_word("stall_addr4", o_imem_addr, 32'h0000_0014);
        i_imem_req_ready = 1'b1;
        @(negedge i_clk);
        i_imem_req_ready = 1'b0;
        check_bit("accepted_on_4th", o_imem_req_valid, 1'b0);
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = 32'h0000_0067;
        @(negedge i_clk);
        i_imem_rsp_valid = 1'b0;
        check_bit("stall_instr_valid", o_instr_valid, 1'b1);
        check_word("stall_pc", o_pc, 32'h0000_0014);
        i_pc_sel      = PC_ALU_OUT;
        i_alu_out     = 32'h0000_0106;
        i_instr_ready = 1'b1;
        @(negedge i_clk);
        i_instr_ready = 1'b0;
        i_pc_sel      = PC_INCR;
`ifdef FETCH_ALIGN_CHECK_EN
        check_bit("fault_set", o_fault, 1'b1);
        check_word("fault_pc", o_pc, 32'h0000_0106);
        check_bit("fault_no_instr", o_instr_valid, 1'b0);
        for (int c = 0; c < 4; c++) begin
            check_bit("fault_no_req", o_imem_req_valid, 1'b0);
            check_bit("fault_sticky", o_fault, 1'b1);
            @(negedge i_clk);
        end
`else
        check_bit("no_fault", o_fault, 1'b0);
        check_bit("aligned_req", o_imem_req_valid, 1'b1);
        check_word("aligned_addr", o_imem_addr, 32'h0000_0104);
`endif

        // Reset, start a fetch, then reset again while waiting for the response.
        i_rst_n = 1'b0;
        #1;
        check_bit("rst2_fault", o_fault, 1'b0);
        check_word("rst2_pc", o_pc, 32'h0);
        check_bit("rst2_req", o_imem_req_valid, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_bit("rst2_req_after", o_imem_req_valid, 1'b1);
        i_imem_req_ready = 1'b1;
        @(negedge i_clk);
        i_imem_req_ready = 1'b0;
        check_bit("rst3_in_wait", o_imem_req_valid, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check_bit("rst3_instr_valid", o_instr_valid, 1'b0);
        check_bit("rst3_req_valid", o_imem_req_valid, 1'b0);
        @(negedge i_clk);
        i_rst_n          = 1'b1;
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge i_clk);
        check_bit("stale_ignored_a", o_instr_valid, 1'b0);
        check_bit("fresh_req", o_imem_req_valid, 1'b1);
        check_word("fresh_addr", o_imem_addr, 32'h0);
        @(negedge i_clk);
        check_bit("stale_ignored_b", o_instr_valid, 1'b0);
        check_bit("fresh_req_held", o_imem_req_valid, 1'b1);
        i_imem_rsp_valid = 1'b0;
        i_imem_req_ready = 1'b1;
        @(negedge i_clk);
        i_imem_req_ready = 1'b0;
        check_bit("no_valid_before_rsp", o_instr_valid, 1'b0);
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = 32'h0070_0193;
        @(negedge i_clk);
        i_imem_rsp_valid = 1'b0;
        check_bit("fresh_instr_valid", o_instr_valid, 1'b1);
        check_word("fresh_instr", o_instr, 32'h0070_0193);
        check_word("fresh_pc", o_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
